// File: rtl/buf_share_arb_pkg.sv
// buf_share_arb_pkg: FSM state encoding and grant hold-limit constants shared by buf_share_arb and rr_pick
package buf_share_arb_pkg;
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;
    localparam int MAX_HOLD_MIN = 1;
    localparam int MAX_HOLD_MAX = 255;
    function automatic int clamp_hold(input int h);
        return h < MAX_HOLD_MIN ? MAX_HOLD_MIN : h > MAX_HOLD_MAX ? MAX_HOLD_MAX : h;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority search of req from start with wrap (in: req, start, excl_last; out: found, idx)
module rr_pick
    import buf_share_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic          excl_last,
    output logic          found,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] j;
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = IW'((int'(start) + i) % N);
            if (!found && !(excl_last && i == N - 1) && req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end
endmodule

// File: rtl/buf_share_arb.sv
// buf_share_arb: round-robin shared buffer/inverter lane (in: clock, reset, req, din, inv_mask; out: grant, grant_valid, grant_id, dout, dout_valid)
module buf_share_arb
    import buf_share_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int MAX_HOLD = 8,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] din,
    input  logic [NUM_REQ-1:0] inv_mask,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic               dout,
    output logic               dout_valid
);
    localparam logic [7:0] HOLD_LAST = 8'(clamp_hold(MAX_HOLD) - 1);
    logic               state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    gid_q, gid_d, ptr_q, ptr_d;
    logic [7:0]         hold_q, hold_d;
    logic               dout_q, dout_d, dv_q, dv_d;
    logic               timeout, rel, excl, found;
    logic [ID_W-1:0]    nxt, start, pick_idx;
    always_comb begin
        nxt     = ID_W'((int'(gid_q) + 1) % NUM_REQ);
        timeout = hold_q == HOLD_LAST;
        rel     = !req[gid_q] || timeout;
        start   = state_q == ST_GRANT ? nxt : ptr_q;
        // the owner competes again only on timeout; a dropped req excludes itself anyway
        excl    = state_q == ST_GRANT && !timeout;
    end
    rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
        .req      (req),
        .start    (start),
        .excl_last(excl),
        .found    (found),
        .idx      (pick_idx)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            dout_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
        end
    end
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q + 8'd1;
        if (state_q == ST_IDLE || rel) begin
            ptr_d   = state_q == ST_GRANT ? nxt : ptr_q;
            state_d = found ? ST_GRANT : ST_IDLE;
            grant_d = found ? NUM_REQ'(1) << pick_idx : '0;
            gid_d   = found ? pick_idx : '0;
            hold_d  = '0;
        end
        dout_d = grant_valid ? din[gid_q] ^ inv_mask[gid_q] : 1'b0;
        dv_d   = grant_valid;
    end
    always_comb begin
        grant       = grant_q;
        grant_valid = state_q == ST_GRANT;
        grant_id    = gid_q;
        dout        = dout_q;
        dout_valid  = dv_q;
    end
endmodule

// File: tb/tb_buf_share_arb.sv
// tb_buf_share_arb: directed self-checking bench for buf_share_arb
module tb_buf_share_arb;
    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req, din, inv_mask, grant;
    logic       grant_valid, dout, dout_valid;
    logic [1:0] grant_id;
    int         checks = 0;
    int         errors = 0;

    buf_share_arb #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .din        (din),
        .inv_mask   (inv_mask),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        din = '0;
        inv_mask = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 4'hf;
        din = 4'hf;
        inv_mask = '0;
        step();
        step();
        checks++;
        if ({grant, grant_valid, grant_id, dout, dout_valid} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want %b", {grant, grant_valid, grant_id, dout, dout_valid}, 9'b0);
        end
        reset = 1'b0;
        req = '0;
        din = '0;
        step();
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0010;
        din = 4'b0010;
        step();
        checks++;
        if ({grant, grant_valid, grant_id, dout_valid} !== {4'b0010, 1'b1, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL single_grant got %b want %b", {grant, grant_valid, grant_id, dout_valid}, {4'b0010, 1'b1, 2'd1, 1'b0});
        end
        step();
        checks++;
        if ({dout, dout_valid} !== 2'b11) begin
            errors++;
            $display("FAIL single_dout got %b want %b", {dout, dout_valid}, 2'b11);
        end
        req = '0;
        step();
        checks++;
        if ({grant, grant_valid, dout_valid} !== {4'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL single_release got %b want %b", {grant, grant_valid, dout_valid}, {4'b0, 1'b0, 1'b1});
        end
        step();
        checks++;
        if ({dout, dout_valid} !== 2'b00) begin
            errors++;
            $display("FAIL single_dout_drop got %b want %b", {dout, dout_valid}, 2'b00);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        do_reset();
        req = 4'hf;
        for (int i = 0; i < 9; i++) begin
            step();
            exp = 2'((i / 2) % 4);
            checks++;
            if ({grant_valid, grant_id, grant} !== {1'b1, exp, 4'(1) << exp}) begin
                errors++;
                $display("FAIL rr_owner[%0d] got %b want %b", i, {grant_valid, grant_id, grant}, {1'b1, exp, 4'(1) << exp});
            end
            req = (i % 2 == 1) ? ~(4'(1) << exp) : 4'hf;
        end
    endtask

    task automatic test_timeout();
        logic [1:0] exp;
        do_reset();
        req = 4'b0101;
        for (int i = 0; i < 17; i++) begin
            step();
            exp = (i >= 8 && i < 16) ? 2'd2 : 2'd0;
            checks++;
            if ({grant_valid, grant_id} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL timeout_owner[%0d] got %b want %b", i, {grant_valid, grant_id}, {1'b1, exp});
            end
        end
    endtask

    task automatic test_sole_timeout();
        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({grant, dut.hold_q} !== {4'b1000, 8'(i % 8)}) begin
                errors++;
                $display("FAIL sole_hold[%0d] got %b want %b", i, {grant, dut.hold_q}, {4'b1000, 8'(i % 8)});
            end
        end
    endtask

    task automatic test_inversion();
        logic [3:0] seq;
        seq = 4'b0110;
        do_reset();
        req = 4'b0100;
        inv_mask = 4'b0100;
        din = 4'b1000;
        step();
        for (int i = 0; i < 4; i++) begin
            din[2] = seq[i];
            inv_mask[3] = i[0];
            step();
            checks++;
            if ({dout, dout_valid} !== {~seq[i], 1'b1}) begin
                errors++;
                $display("FAIL inv_dout[%0d] got %b want %b", i, {dout, dout_valid}, {~seq[i], 1'b1});
            end
        end
        req = '0;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if ({grant_id, dut.hold_q} !== {2'd1, 8'd5}) begin
            errors++;
            $display("FAIL mid_setup got %b want %b", {grant_id, dut.hold_q}, {2'd1, 8'd5});
        end
        req = 4'hf;
        reset = 1'b1;
        step();
        checks++;
        if ({grant, grant_valid, grant_id, dout, dout_valid, dut.ptr_q} !== 11'b0) begin
            errors++;
            $display("FAIL mid_reset got %b want %b", {grant, grant_valid, grant_id, dout, dout_valid, dut.ptr_q}, 11'b0);
        end
        reset = 1'b0;
        step();
        checks++;
        if ({grant, grant_id} !== {4'b0001, 2'd0}) begin
            errors++;
            $display("FAIL mid_first_owner got %b want %b", {grant, grant_id}, {4'b0001, 2'd0});
        end
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        din = '0;
        inv_mask = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_sole_timeout();
        test_inversion();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
